pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer for the single-cycle core: holds the PC and selects next-PC from sequential advance, unconditional branch, NZCV-conditional branch and subroutine return. It adds a circular return-address stack for call/return, a stall hold, target alignment checking and full 16-code condition evaluation. It sits between the decoder/ALU flag register and instruction memory, driving the fetch address every cycle.

## Interface
- ADDR_W, 32, PC and target width in bits
- INSTR_BYTES, 4, PC increment; power of two, ≥1
- RAS_DEPTH, 4, return-stack entries; power of two, ≥2
- RESET_PC, 0, PC value loaded on reset
- Clk  input  1  clock, rising edge
- Reset  input  1  synchronous, active-high
- Stall  input  1  hold PC and stack; all requests ignored
- NextPc  input  1  advance PC by INSTR_BYTES
- BrUncond  input  1  unconditional branch to BrTarget
- BrCond  input  1  conditional branch to BrTarget per Cond/Flags
- Call  input  1  qualifies a taken branch: push PC+INSTR_BYTES
- Ret  input  1  pop stack top into PC
- Cond  input  4  condition code
- Flags  input  4  {N,C,Z,V}, bit3=N, bit2=C, bit1=Z, bit0=V
- BrTarget  input  ADDR_W  branch target address
- Pc  output  ADDR_W  current fetch address (registered)
- Taken  output  1  registered; PC was loaded from target or stack this cycle
- MisalignErr  output  1  registered one-cycle pulse, misaligned target
- RasEmpty  output  1  stack count == 0
- RasFull  output  1  stack count == RAS_DEPTH
- RasOvf  output  1  sticky, a push discarded the oldest entry
- RasUnf  output  1  sticky, Ret issued on empty stack

## Operation
- Priority per cycle: Reset > Stall > Ret > BrUncond > BrCond > NextPc > hold.
- Ret: non-empty → Pc ← top, pop, Taken=1. Empty → Pc ← Pc+INSTR_BYTES, RasUnf set, Taken=0.
- BrUncond: Pc ← target, Taken=1. BrCond: taken per Cond else Pc ← Pc+INSTR_BYTES, Taken=0.
- Conditions: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
- Call pushes Pc+INSTR_BYTES only when the branch is taken; Call with not-taken BrCond, with Ret, or alone does nothing.
- Push when full: overwrite oldest entry (circular), count stays RAS_DEPTH, RasOvf set.
- Target low log2(INSTR_BYTES) bits nonzero: bits forced to 0 in loaded PC, MisalignErr pulses; branch/push still performed.
- All additions modulo 2^ADDR_W; Pc = 2^ADDR_W−INSTR_BYTES advances to 0.
- No request and no Stall: Pc holds.

## Timing
- Reset: Pc=RESET_PC, Taken=0, MisalignErr=0, count=0, RasEmpty=1, RasFull=0, RasOvf=0, RasUnf=0; stack contents don't-care.
- Latency 1: request sampled at edge N, Pc/Taken/MisalignErr reflect it after edge N.
- Flags/Cond sampled same edge as BrCond; no internal flag storage.
- Stall: Taken and MisalignErr cleared to 0; sticky flags hold.
- Reset mid-sequence discards stack and clears sticky flags same edge.
- RasEmpty/RasFull combinational from registered count.

## Structure
- Package pc_seq_pkg: condition-code localparams (COND_EQ..COND_NV), flag bit indices (FLAG_N=3, FLAG_C=2, FLAG_Z=1, FLAG_V=0), cond_eval function.
- Sub-module return_stack: RAS_DEPTH×ADDR_W circular array, top pointer, count, push/pop/overflow logic.

## Test plan
- Reset, 3× NextPc, INSTR_BYTES=4 → Pc 0,4,8,0xC; Taken=0 throughout.
- Flags=4'b0010 (Z), BrCond Cond=0 target 0x100 → Pc=0x100, Taken=1; Cond=1 from Pc=0x100 → Pc=0x104, Taken=0.
- Sweep all 16 Cond × 16 Flags with BrCond → taken iff table above; Cond=F never, Cond=E always.
- Pc=0x20, BrUncond+Call target 0x400 → Pc=0x400, push 0x24; Ret → Pc=0x24, RasEmpty=1; Ret again → Pc=0x28, RasUnf=1.
- RAS_DEPTH=4, 5 nested calls returning 0x10,0x20,0x30,0x40,0x50 → RasOvf=1; 4 Rets yield 0x50,0x40,0x30,0x20, then RasEmpty=1.
- Target 0x103 → Pc=0x100, MisalignErr one cycle; Stall with BrUncond → Pc unchanged; PC 0xFFFFFFFC + NextPc → 0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer:
// condition codes, NZCV flag positions and the condition evaluator.
package pc_seq_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    function automatic logic cond_eval(input logic [3:0] cond,
                                       input logic [3:0] flags);
        logic n, c, z, v, r;
        n = flags[FLAG_N];
        c = flags[FLAG_C];
        z = flags[FLAG_Z];
        v = flags[FLAG_V];
        r = 1'b0;
        unique case (cond)
            COND_EQ: r = z;
            COND_NE: r = !z;
            COND_CS: r = c;
            COND_CC: r = !c;
            COND_MI: r = n;
            COND_PL: r = !n;
            COND_VS: r = v;
            COND_VC: r = !v;
            COND_HI: r = c && !z;
            COND_LS: r = !c || z;
            COND_GE: r = (n == v);
            COND_LT: r = (n != v);
            COND_GT: r = !z && (n == v);
            COND_LE: r = z || (n != v);
            COND_AL: r = 1'b1;
            COND_NV: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Circular return-address stack; a push when full overwrites the
// oldest entry, which is exactly the slot the write pointer is on.
module return_stack #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full,
    output logic              ovf
);
    localparam int PW = $clog2(RAS_DEPTH);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     top_idx;
    logic [PW:0]       count;

    assign top_idx = ptr - PW'(1);
    assign top     = mem[top_idx];
    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(RAS_DEPTH));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (push) begin
            ptr <= ptr + PW'(1);
            if (full) ovf <= 1'b1;
            else      count <= count + (PW+1)'(1);
        end else if (pop && !empty) begin
            ptr   <= top_idx;
            count <= count - (PW+1)'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset && push) mem[ptr] <= push_data;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential advance, branches,
// NZCV-conditional branches and call/return through the stack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                INSTR_BYTES = 4,
    parameter int                RAS_DEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              NextPc,
    input  logic              BrUncond,
    input  logic              BrCond,
    input  logic              Call,
    input  logic              Ret,
    input  logic [3:0]        Cond,
    input  logic [3:0]        Flags,
    input  logic [ADDR_W-1:0] BrTarget,
    output logic [ADDR_W-1:0] Pc,
    output logic              Taken,
    output logic              MisalignErr,
    output logic              RasEmpty,
    output logic              RasFull,
    output logic              RasOvf,
    output logic              RasUnf
);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INSTR_BYTES - 1);

    logic [ADDR_W-1:0] pc_inc, pc_nxt, ras_top;
    logic              taken_nxt, mis_nxt, unf_set;
    logic              push, pop, load;

    assign pc_inc = Pc + ADDR_W'(INSTR_BYTES);

    always_comb begin
        pc_nxt    = Pc;
        taken_nxt = 1'b0;
        mis_nxt   = 1'b0;
        unf_set   = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        load      = 1'b0;
        if (Stall) begin
            pc_nxt = Pc;
        end else if (Ret) begin
            if (!RasEmpty) begin
                pc_nxt    = ras_top;
                pop       = 1'b1;
                taken_nxt = 1'b1;
            end else begin
                pc_nxt  = pc_inc;
                unf_set = 1'b1;
            end
        end else if (BrUncond || (BrCond && cond_eval(Cond, Flags))) begin
            load = 1'b1;
        end else if (BrCond || NextPc) begin
            pc_nxt = pc_inc;
        end
        // Misaligned targets are still taken, with the low bits dropped.
        if (load) begin
            pc_nxt    = BrTarget & ~LOW_MASK;
            taken_nxt = 1'b1;
            mis_nxt   = |(BrTarget & LOW_MASK);
            push      = Call;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Pc          <= RESET_PC;
            Taken       <= 1'b0;
            MisalignErr <= 1'b0;
            RasUnf      <= 1'b0;
        end else begin
            Pc          <= pc_nxt;
            Taken       <= taken_nxt;
            MisalignErr <= mis_nxt;
            if (unf_set) RasUnf <= 1'b1;
        end
    end

    return_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .Clk       (Clk),
        .Reset     (Reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .empty     (RasEmpty),
        .full      (RasFull),
        .ovf       (RasOvf)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: vector table, hand sequences, condition
// sweep and random traffic against a queue-based reference model.
module tb_pc_sequencer;

    logic        Clk = 1'b0;
    logic        Reset, Stall, NextPc, BrUncond, BrCond, Call, Ret;
    logic [3:0]  Cond, Flags;
    logic [31:0] BrTarget, Pc;
    logic        Taken, MisalignErr, RasEmpty, RasFull, RasOvf, RasUnf;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        rst, stall, nxt, bu, bc, call, ret;
        logic [3:0]  cond, flags;
        logic [31:0] tgt;
    } req_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken, mis, empty, full, ovf, unf;
    } exp_t;

    typedef struct {
        req_t        r;
        logic [31:0] pc;
        logic        taken;
    } vec_t;

    localparam logic [6:0] C_RST = 7'b1000000;
    localparam logic [6:0] C_STL = 7'b0100000;
    localparam logic [6:0] C_NXT = 7'b0010000;
    localparam logic [6:0] C_BU  = 7'b0001000;
    localparam logic [6:0] C_BC  = 7'b0000100;
    localparam logic [6:0] C_CAL = 7'b0000010;
    localparam logic [6:0] C_RET = 7'b0000001;

    exp_t        sb[$];
    logic [31:0] m_stk[$];
    logic [31:0] m_pc;
    logic        m_ovf, m_unf;

    pc_sequencer dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .NextPc(NextPc),
        .BrUncond(BrUncond), .BrCond(BrCond), .Call(Call), .Ret(Ret),
        .Cond(Cond), .Flags(Flags), .BrTarget(BrTarget), .Pc(Pc),
        .Taken(Taken), .MisalignErr(MisalignErr), .RasEmpty(RasEmpty),
        .RasFull(RasFull), .RasOvf(RasOvf), .RasUnf(RasUnf)
    );

    always #5 Clk = ~Clk;

    function automatic req_t rq(input logic [6:0] ctl, input logic [3:0] c,
                                input logic [3:0] f, input logic [31:0] t);
        return req_t'({ctl, c, f, t});
    endfunction

    // Eight base tests, odd codes are the complements; code F is !AL.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, cy, z, v, b;
        n = f[3]; cy = f[2]; z = f[1]; v = f[0];
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cy;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cy & ~z;
            3'd5: b = (n == v);
            3'd6: b = ~z & (n == v);
            default: b = 1'b1;
        endcase
        return b ^ c[0];
    endfunction

    function automatic exp_t model(input req_t r);
        exp_t e;
        logic ld;
        e = '0;
        ld = 1'b0;
        if (r.rst) begin
            m_pc = 32'h0; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else if (r.stall) begin
        end else if (r.ret) begin
            if (m_stk.size() > 0) begin
                m_pc = m_stk.pop_back();
                e.taken = 1'b1;
            end else begin
                m_pc = m_pc + 32'd4;
                m_unf = 1'b1;
            end
        end else if (r.bu || (r.bc && ref_cond(r.cond, r.flags))) begin
            ld = 1'b1;
        end else if (r.bc || r.nxt) begin
            m_pc = m_pc + 32'd4;
        end
        if (ld) begin
            if (r.call) begin
                if (m_stk.size() == 4) begin
                    void'(m_stk.pop_front());
                    m_ovf = 1'b1;
                end
                m_stk.push_back(m_pc + 32'd4);
            end
            m_pc = {r.tgt[31:2], 2'b00};
            e.taken = 1'b1;
            e.mis = (r.tgt[1:0] != 2'b00);
        end
        e.pc = m_pc;
        e.empty = (m_stk.size() == 0);
        e.full = (m_stk.size() == 4);
        e.ovf = m_ovf;
        e.unf = m_unf;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input req_t r);
        exp_t e;
        sb.push_back(model(r));
        Reset = r.rst; Stall = r.stall; NextPc = r.nxt; BrUncond = r.bu;
        BrCond = r.bc; Call = r.call; Ret = r.ret; Cond = r.cond;
        Flags = r.flags; BrTarget = r.tgt;
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        chk("pc", Pc, e.pc);
        chk("taken", Taken, e.taken);
        chk("mis", MisalignErr, e.mis);
        chk("empty", RasEmpty, e.empty);
        chk("full", RasFull, e.full);
        chk("ovf", RasOvf, e.ovf);
        chk("unf", RasUnf, e.unf);
    endtask

    vec_t vt[16];

    initial begin
        logic [6:0]  ctl;
        logic [31:0] tg;

        vt[0]  = '{rq(C_NXT, 0, 0, 0), 32'h4, 1'b0};
        vt[1]  = '{rq(C_NXT, 0, 0, 0), 32'h8, 1'b0};
        vt[2]  = '{rq(C_NXT, 0, 0, 0), 32'hC, 1'b0};
        vt[3]  = '{rq(C_BC, 4'h0, 4'b0010, 32'h100), 32'h100, 1'b1};
        vt[4]  = '{rq(C_BC, 4'h1, 4'b0010, 32'h200), 32'h104, 1'b0};
        vt[5]  = '{rq(C_BU, 0, 0, 32'h20), 32'h20, 1'b1};
        vt[6]  = '{rq(C_BU | C_CAL, 0, 0, 32'h400), 32'h400, 1'b1};
        vt[7]  = '{rq(C_RET, 0, 0, 0), 32'h24, 1'b1};
        vt[8]  = '{rq(C_RET, 0, 0, 0), 32'h28, 1'b0};
        vt[9]  = '{rq(C_BU, 0, 0, 32'h103), 32'h100, 1'b1};
        vt[10] = '{rq(C_STL | C_BU, 0, 0, 32'h500), 32'h100, 1'b0};
        vt[11] = '{rq(7'b0, 0, 0, 0), 32'h100, 1'b0};
        vt[12] = '{rq(C_CAL, 0, 0, 32'h700), 32'h100, 1'b0};
        vt[13] = '{rq(C_BC | C_CAL, 4'hF, 0, 32'h600), 32'h104, 1'b0};
        vt[14] = '{rq(C_BU, 0, 0, 32'hFFFF_FFFC), 32'hFFFF_FFFC, 1'b1};
        vt[15] = '{rq(C_NXT, 0, 0, 0), 32'h0, 1'b0};

        step(rq(C_RST, 0, 0, 0));
        chk("rst_pc", Pc, 32'h0);
        chk("rst_empty", RasEmpty, 1);
        chk("rst_flags", {Taken, MisalignErr, RasFull, RasOvf, RasUnf}, 0);

        for (int i = 0; i < 16; i++) begin
            step(vt[i].r);
            chk("vpc", Pc, vt[i].pc);
            chk("vtaken", Taken, vt[i].taken);
            if (i == 7)  chk("ret_empty", RasEmpty, 1);
            if (i == 8)  chk("ret_unf", RasUnf, 1);
            if (i == 9)  chk("mis_pulse", MisalignErr, 1);
            if (i == 10) chk("mis_clear", MisalignErr, 0);
        end

        // Nested calls, fifth one overflows the 4-deep stack.
        step(rq(C_RST, 0, 0, 0));
        chk("rst_unf", RasUnf, 0);
        step(rq(C_BU, 0, 0, 32'hC));
        for (int i = 1; i <= 5; i++) begin
            tg = (i == 5) ? 32'h1000 : 32'(i * 16 + 12);
            step(rq(C_BU | C_CAL, 0, 0, tg));
        end
        chk("ovf", RasOvf, 1);
        chk("full", RasFull, 1);
        step(rq(C_STL | C_RET, 0, 0, 0));
        chk("stall_ret", Pc, 32'h1000);
        for (int i = 0; i < 4; i++) begin
            step(rq(C_RET, 0, 0, 0));
            chk("nest_ret", Pc, 32'(32'h50 - i * 16));
        end
        chk("nest_empty", RasEmpty, 1);
        step(rq(C_RST | C_BU, 0, 0, 32'h40));
        chk("rst_ovf", RasOvf, 0);
        chk("rst_pc2", Pc, 32'h0);

        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                step(rq(C_BC, 4'(c), 4'(f), 32'h8000 + 32'(c * 64 + f * 4)));
                if (c == 14) chk("cond_al", Taken, 1);
                if (c == 15) chk("cond_nv", Taken, 0);
            end
        end

        for (int i = 0; i < 400; i++) begin
            ctl = 7'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) ctl = ctl & ~C_STL;
            if ($urandom_range(0, 60) == 0) ctl = ctl | C_RST;
            tg = $urandom;
            if ($urandom_range(0, 3) != 0) tg[1:0] = 2'b00;
            step(rq(ctl, 4'($urandom), 4'($urandom), tg));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
